// File: rtl/redun_to_bin_if.sv
// Handshake bundle between the redundant Montgomery squarer and the
// redundant-to-binary converter. The master side (upstream/downstream
// environment) drives i_*; the slave side (converter) drives o_*.
`timescale 1ns/1ps
interface redun_to_bin_if #(
  parameter int NUM_WRDS = 4,
  parameter int WRD_BITS = 16
);
  logic [WRD_BITS:0]            i_mul [NUM_WRDS];
  logic                         i_val;
  logic                         o_rdy;
  logic [NUM_WRDS*WRD_BITS-1:0] o_dat;
  logic                         o_val;
  logic                         i_rdy;
  logic                         o_err;

  modport master (
    output i_mul, i_val, i_rdy,
    input  o_rdy, o_dat, o_val, o_err
  );

  modport slave (
    input  i_mul, i_val, i_rdy,
    output o_rdy, o_dat, o_val, o_err
  );
endinterface

// File: rtl/redun_to_bin.sv
// redun_to_bin: converts a redundant NUM_WRDS x (WRD_BITS+1) value into a
// canonical binary residue. Word-serial carry propagation, then (when the
// REDUN_TO_BIN_REDUCE_EN macro is defined) word-serial conditional
// subtraction of P, at most MAX_SUB committed passes. Without the macro the
// subtraction stage is absent and the carry-propagated low bits are output.
`timescale 1ns/1ps
module redun_to_bin #(
  parameter int                           NUM_WRDS = 4,
  parameter int                           WRD_BITS = 16,
  parameter logic [NUM_WRDS*WRD_BITS-1:0] P        = 64'hFFFF_FFFF_FFFF_FFC5,
  parameter int                           EXT_BITS = 2,
  parameter int                           MAX_SUB  = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  redun_to_bin_if.slave bus
);
  localparam int CW = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

  typedef enum logic [1:0] {IDLE, CARRY, SUB, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WRD_BITS:0]    cap_reg [NUM_WRDS];
  logic [WRD_BITS-1:0]  val_reg [NUM_WRDS];
  logic [EXT_BITS-1:0]  hi_reg;
  logic [1:0]           carry_reg;   // carry in CARRY, bit 0 is the borrow in SUB
  logic [CW-1:0]        cnt_reg;
  logic                 err_reg;
  logic                 last_word;
  logic [WRD_BITS+1:0]  sum_w;

`ifdef REDUN_TO_BIN_REDUCE_EN
  localparam int KW = $clog2(MAX_SUB + 1);
  logic [WRD_BITS-1:0]  tmp_reg [NUM_WRDS];
  logic [KW-1:0]        k_reg, k_inc;
  logic [WRD_BITS:0]    diff_w;
  logic [EXT_BITS:0]    hi_diff;
  logic                 pass_borrow;
`else
  logic unused_cfg;
  assign unused_cfg = ^{P, 32'(MAX_SUB)};
`endif

  // Per-word arithmetic for the word selected by the counter
  always_comb begin
    last_word = (cnt_reg == CW'(NUM_WRDS - 1));
    sum_w     = {1'b0, cap_reg[cnt_reg]} + {{WRD_BITS{1'b0}}, carry_reg};
`ifdef REDUN_TO_BIN_REDUCE_EN
    diff_w      = {1'b0, val_reg[cnt_reg]} - {1'b0, P[cnt_reg*WRD_BITS +: WRD_BITS]}
                  - {{WRD_BITS{1'b0}}, carry_reg[0]};
    // Borrow out of the headroom word is the only "value < P" signal
    hi_diff     = {1'b0, hi_reg} - {{EXT_BITS{1'b0}}, diff_w[WRD_BITS]};
    pass_borrow = hi_diff[EXT_BITS];
    k_inc       = k_reg + KW'(1);
`endif
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (bus.i_val) state_next = CARRY;
`ifdef REDUN_TO_BIN_REDUCE_EN
      CARRY: if (last_word) state_next = SUB;
      SUB:   if (last_word && (pass_borrow || k_inc == KW'(MAX_SUB))) state_next = DONE;
`else
      CARRY: if (last_word) state_next = DONE;
`endif
      DONE:  if (bus.i_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, carry propagation and subtraction passes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_WRDS; i++) begin
        cap_reg[i] <= '0;
        val_reg[i] <= '0;
`ifdef REDUN_TO_BIN_REDUCE_EN
        tmp_reg[i] <= '0;
`endif
      end
      hi_reg    <= '0;
      carry_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
`ifdef REDUN_TO_BIN_REDUCE_EN
      k_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (bus.i_val) begin
          for (int i = 0; i < NUM_WRDS; i++) cap_reg[i] <= bus.i_mul[i];
          carry_reg <= '0;
          cnt_reg   <= '0;
          err_reg   <= 1'b0;
          hi_reg    <= '0;
`ifdef REDUN_TO_BIN_REDUCE_EN
          k_reg     <= '0;
`endif
        end
        CARRY: begin
          val_reg[cnt_reg] <= sum_w[WRD_BITS-1:0];
          carry_reg        <= sum_w[WRD_BITS+1:WRD_BITS];
          cnt_reg          <= cnt_reg + CW'(1);
          if (last_word) begin
            hi_reg    <= EXT_BITS'(sum_w[WRD_BITS+1:WRD_BITS]);
            carry_reg <= '0;
            cnt_reg   <= '0;
          end
        end
`ifdef REDUN_TO_BIN_REDUCE_EN
        SUB: begin
          tmp_reg[cnt_reg] <= diff_w[WRD_BITS-1:0];
          carry_reg        <= {1'b0, diff_w[WRD_BITS]};
          cnt_reg          <= cnt_reg + CW'(1);
          if (last_word) begin
            carry_reg <= '0;
            cnt_reg   <= '0;
            // No final borrow: value >= P, so the difference replaces it
            if (!pass_borrow) begin
              for (int i = 0; i < NUM_WRDS - 1; i++) val_reg[i] <= tmp_reg[i];
              val_reg[NUM_WRDS-1] <= diff_w[WRD_BITS-1:0];
              hi_reg              <= hi_diff[EXT_BITS-1:0];
              k_reg               <= k_inc;
              if (k_inc == KW'(MAX_SUB)) err_reg <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.o_rdy = (state_reg == IDLE);
  assign bus.o_val = (state_reg == DONE);
  assign bus.o_err = (state_reg == DONE) && (err_reg || (hi_reg != '0));

  for (genvar gi = 0; gi < NUM_WRDS; gi++) begin : g_dat
    assign bus.o_dat[gi*WRD_BITS +: WRD_BITS] = val_reg[gi];
  end
endmodule

// File: tb/tb_redun_to_bin.sv
// Self-checking bench for redun_to_bin. Two instances: MAX_SUB=4 (main)
// and MAX_SUB=1 (error path). Expected results come from a big-integer
// model of the reduction rule, following whichever build the macro selects.
`timescale 1ns/1ps
module tb_redun_to_bin;
  localparam int N = 4;
  localparam int W = 16;
  localparam logic [127:0] PM = 128'hFFFF_FFFF_FFFF_FFC5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  redun_to_bin_if #(.NUM_WRDS(N), .WRD_BITS(W)) bus ();
  redun_to_bin_if #(.NUM_WRDS(N), .WRD_BITS(W)) bus1 ();

  redun_to_bin #(.NUM_WRDS(N), .WRD_BITS(W), .P(64'hFFFF_FFFF_FFFF_FFC5),
                 .EXT_BITS(2), .MAX_SUB(4)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  redun_to_bin #(.NUM_WRDS(N), .WRD_BITS(W), .P(64'hFFFF_FFFF_FFFF_FFC5),
                 .EXT_BITS(2), .MAX_SUB(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );

  // Reference: value as an integer, repeated subtraction of P
  function automatic void model(input logic [67:0] wp, input int ms,
                                output logic [63:0] dat, output logic err, output int lat);
    logic [127:0] v;
    int k;
    int passes;
    v = '0; k = 0; passes = 0;
    for (int i = 0; i < N; i++) v = v + (128'(wp[i*17 +: 17]) << (W*i));
`ifdef REDUN_TO_BIN_REDUCE_EN
    while (v >= PM && k < ms) begin
      v = v - PM;
      k++;
    end
    passes = (k == ms) ? k : k + 1;
    err = (k == ms) || (v[127:64] != 0);
`else
    err = (v[127:64] != 0);
`endif
    dat = v[63:0];
    lat = N * (1 + passes);
  endfunction

  function automatic logic [67:0] rand_words();
    logic [67:0] r;
    for (int i = 0; i < N; i++) r[i*17 +: 17] = 17'($urandom_range(0, 17'h1FFFF));
    return r;
  endfunction

  // Drives one input transaction and waits (bounded) for o_val.
  // Entered and left #1 after a rising edge.
  task automatic run_txn(input bit sel, input logic [67:0] wp,
                         output logic [63:0] dat, output logic err, output int lat, output bit to);
    int guard;
    logic rdy, vld;
    to = 1'b0; lat = 0; dat = '0; err = 1'b0; guard = 0;
    for (int i = 0; i < N; i++) begin
      if (sel) bus1.i_mul[i] = wp[i*17 +: 17];
      else     bus.i_mul[i]  = wp[i*17 +: 17];
    end
    if (sel) bus1.i_val = 1'b1; else bus.i_val = 1'b1;
    rdy = sel ? bus1.o_rdy : bus.o_rdy;
    while (!rdy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
      rdy = sel ? bus1.o_rdy : bus.o_rdy;
    end
    if (!rdy) begin
      to = 1'b1;
      if (sel) bus1.i_val = 1'b0; else bus.i_val = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (sel) bus1.i_val = 1'b0; else bus.i_val = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      vld = sel ? bus1.o_val : bus.o_val;
    end while (!vld && lat < 200);
    if (!vld) to = 1'b1;
    dat = sel ? bus1.o_dat : bus.o_dat;
    err = sel ? bus1.o_err : bus.o_err;
    $display("txn dut%0d in=%h dat=%h err=%0d lat=%0d", sel, wp, dat, err, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.o_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", bus.o_rdy); end
    checks++; if (bus.o_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b want 0", bus.o_val); end
    checks++; if (bus.o_dat !== 64'h0) begin errors++; $display("FAIL reset_dat got %h want 0", bus.o_dat); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.o_err); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [67:0] vec [4];
    logic [63:0] dat, edat;
    logic err, eerr;
    int lat, elat;
    bit to;
    vec[0] = 68'h0;
    vec[1] = {17'h0, 17'h0, 17'h0, 17'h1FFFF};
    vec[2] = {17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFC5};
    vec[3] = {17'h1FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FF8F};  // 2P+5
    for (int t = 0; t < 4; t++) begin
      model(vec[t], 4, edat, eerr, elat);
      run_txn(1'b0, vec[t], dat, err, lat, to);
      checks++; if (to) begin errors++; $display("FAIL directed%0d_timeout got no o_val want o_val", t); end
      checks++; if (dat !== edat) begin errors++; $display("FAIL directed%0d_dat got %h want %h", t, dat, edat); end
      checks++; if (err !== eerr) begin errors++; $display("FAIL directed%0d_err got %b want %b", t, err, eerr); end
      checks++; if (lat != elat) begin errors++; $display("FAIL directed%0d_lat got %0d want %0d", t, lat, elat); end
    end
  endtask

  task automatic test_err_path();
    logic [67:0] v;
    logic [63:0] dat, edat;
    logic err, eerr;
    int lat, elat;
    bit to;
    v = {17'h1FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FF8F};
    model(v, 1, edat, eerr, elat);
    run_txn(1'b1, v, dat, err, lat, to);
    checks++; if (to) begin errors++; $display("FAIL errpath_timeout got no o_val want o_val"); end
    checks++; if (dat !== edat) begin errors++; $display("FAIL errpath_dat got %h want %h", dat, edat); end
    checks++; if (err !== eerr) begin errors++; $display("FAIL errpath_err got %b want %b", err, eerr); end
    checks++; if (lat != elat) begin errors++; $display("FAIL errpath_lat got %0d want %0d", lat, elat); end
  endtask

  task automatic test_hold();
    logic [67:0] v;
    logic [63:0] dat, edat;
    logic err, eerr;
    int lat, elat;
    bit to;
    bus.i_rdy = 1'b0;
    v = rand_words();
    model(v, 4, edat, eerr, elat);
    run_txn(1'b0, v, dat, err, lat, to);
    checks++; if (to) begin errors++; $display("FAIL hold_timeout got no o_val want o_val"); end
    checks++; if (dat !== edat) begin errors++; $display("FAIL hold_dat got %h want %h", dat, edat); end
    checks++; if (err !== eerr) begin errors++; $display("FAIL hold_err got %b want %b", err, eerr); end
    for (int c = 0; c < 10; c++) begin
      bus.i_val = (c % 2 == 0);
      for (int i = 0; i < N; i++) bus.i_mul[i] = 17'($urandom_range(0, 17'h1FFFF));
      @(posedge clk); #1;
      checks++; if (bus.o_val !== 1'b1) begin errors++; $display("FAIL hold%0d_val got %b want 1", c, bus.o_val); end
      checks++; if (bus.o_rdy !== 1'b0) begin errors++; $display("FAIL hold%0d_rdy got %b want 0", c, bus.o_rdy); end
      checks++; if (bus.o_dat !== edat) begin errors++; $display("FAIL hold%0d_dat got %h want %h", c, bus.o_dat, edat); end
      checks++; if (bus.o_err !== eerr) begin errors++; $display("FAIL hold%0d_err got %b want %b", c, bus.o_err, eerr); end
    end
    bus.i_val = 1'b0;
    bus.i_rdy = 1'b1;
    v = rand_words();
    model(v, 4, edat, eerr, elat);
    run_txn(1'b0, v, dat, err, lat, to);
    checks++; if (to) begin errors++; $display("FAIL resume_timeout got no o_val want o_val"); end
    checks++; if (dat !== edat) begin errors++; $display("FAIL resume_dat got %h want %h", dat, edat); end
    checks++; if (err !== eerr) begin errors++; $display("FAIL resume_err got %b want %b", err, eerr); end
    checks++; if (lat != elat) begin errors++; $display("FAIL resume_lat got %0d want %0d", lat, elat); end
  endtask

  task automatic test_back_to_back();
    logic [67:0] v;
    logic [63:0] dat, edat;
    logic err, eerr;
    int lat, elat;
    bit to;
    for (int t = 0; t < 25; t++) begin
      v = rand_words();
      if (t < 3) v[67:51] = 17'h1FFFF;  // push into the headroom bits
      model(v, 4, edat, eerr, elat);
      run_txn(1'b0, v, dat, err, lat, to);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got no o_val want o_val", t); end
      checks++; if (dat !== edat) begin errors++; $display("FAIL rand%0d_dat got %h want %h", t, dat, edat); end
      checks++; if (err !== eerr) begin errors++; $display("FAIL rand%0d_err got %b want %b", t, err, eerr); end
      checks++; if (lat != elat) begin errors++; $display("FAIL rand%0d_lat got %0d want %0d", t, lat, elat); end
    end
  endtask

  task automatic test_reset_mid();
    logic [67:0] v;
    logic [63:0] dat, edat;
    logic err, eerr;
    int lat, elat;
    int guard;
    bit to;
    v = {17'h1ABCD, 17'h12345, 17'h0F0F0, 17'h1FFFF};
    for (int i = 0; i < N; i++) bus.i_mul[i] = v[i*17 +: 17];
    bus.i_val = 1'b1;
    guard = 0;
    while (!bus.o_rdy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (!bus.o_rdy) begin errors++; $display("FAIL rstmid_accept got rdy=0 want rdy=1"); end
    @(posedge clk); #1;   // accept edge; first CARRY cycle
    bus.i_val = 1'b0;
    @(posedge clk); #1;   // second CARRY cycle
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.o_val !== 1'b0) begin errors++; $display("FAIL rstmid_val got %b want 0", bus.o_val); end
    checks++; if (bus.o_dat !== 64'h0) begin errors++; $display("FAIL rstmid_dat got %h want 0", bus.o_dat); end
    checks++; if (bus.o_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got %b want 1", bus.o_rdy); end
    rst = 1'b0;
    v = rand_words();
    model(v, 4, edat, eerr, elat);
    run_txn(1'b0, v, dat, err, lat, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_fresh_timeout got no o_val want o_val"); end
    checks++; if (dat !== edat) begin errors++; $display("FAIL rstmid_fresh_dat got %h want %h", dat, edat); end
    checks++; if (err !== eerr) begin errors++; $display("FAIL rstmid_fresh_err got %b want %b", err, eerr); end
    checks++; if (lat != elat) begin errors++; $display("FAIL rstmid_fresh_lat got %0d want %0d", lat, elat); end
  endtask

  initial begin
    bus.i_val  = 1'b0; bus.i_rdy  = 1'b1;
    bus1.i_val = 1'b0; bus1.i_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.i_mul[i]  = '0;
      bus1.i_mul[i] = '0;
    end
    test_reset();
    test_directed();
    test_err_path();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
